// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared refcpu definitions for the instruction fetch unit
package fetch_unit_pkg;

  localparam logic [31:0] REFCPU_RESET_PC = 32'hbfc00000;
  localparam logic [31:0] REFCPU_INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with branch delay slot tracking
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = REFCPU_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_in_delay,
  input  logic        done_valid,
  input  logic        done_branch,
  input  logic [31:0] done_target,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        fatal
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         delayed_q, delayed_d;
  logic [31:0]  delayed_pc_q, delayed_pc_d;
  logic         discard_q, discard_d;
  logic         fatal_q, fatal_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_in_delay_q, inst_in_delay_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      delayed_q       <= 1'b0;
      delayed_pc_q    <= 32'h0;
      discard_q       <= 1'b0;
      fatal_q         <= 1'b0;
      inst_valid_q    <= 1'b0;
      inst_q          <= 32'h0;
      inst_pc_q       <= 32'h0;
      inst_in_delay_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      delayed_q       <= delayed_d;
      delayed_pc_q    <= delayed_pc_d;
      discard_q       <= discard_d;
      fatal_q         <= fatal_d;
      inst_valid_q    <= inst_valid_d;
      inst_q          <= inst_d;
      inst_pc_q       <= inst_pc_d;
      inst_in_delay_q <= inst_in_delay_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    delayed_d       = delayed_q;
    delayed_pc_d    = delayed_pc_q;
    discard_d       = discard_q;
    fatal_d         = fatal_q;
    inst_valid_d    = inst_valid_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    inst_in_delay_d = inst_in_delay_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A stale response from before a flush must drain before the next request goes out
        if (discard_q) begin
          if (iresp_valid) discard_d = 1'b0;
        end else if (ireq_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (iresp_valid) begin
          inst_d          = iresp_data;
          inst_pc_d       = pc_q;
          inst_in_delay_d = delayed_q;
          inst_valid_d    = 1'b1;
          state_d         = HOLD;
        end
      end
      HOLD: begin
        if (done_valid) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
          if (delayed_q) begin
            pc_d      = delayed_pc_q;
            delayed_d = 1'b0;
            if (done_branch) fatal_d = 1'b1;
          end else begin
            pc_d = pc_q + REFCPU_INST_BYTES;
            if (done_branch) begin
              delayed_d    = 1'b1;
              delayed_pc_d = done_target;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_valid) begin
      pc_d         = flush_pc;
      delayed_d    = 1'b0;
      inst_valid_d = 1'b0;
      state_d      = REQ;
      // A response arriving in the flush cycle itself is dropped here and needs no discard
      if ((state_q == WAIT && !iresp_valid) ||
          (state_q == REQ && !discard_q && ireq_ready))
        discard_d = 1'b1;
    end
  end

  assign ireq_valid    = (state_q == REQ) && !discard_q;
  assign ireq_addr     = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_in_delay = inst_in_delay_q;
  assign fatal         = fatal_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'hbfc00000, PC loaded at reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 ireq_valid  out  1  instruction-bus request valid.
REQ-005 ireq_addr  out  32  word address of the request.
REQ-006 ireq_ready  in  1  request accepted this cycle (addr handshake).
REQ-007 iresp_valid  in  1  response data valid (one per accepted request, in order).
REQ-008 iresp_data  in  32  fetched instruction word.
REQ-009 inst_valid  out  1  instruction available to core.
REQ-010 inst  out  32  instruction word.
REQ-011 inst_pc  out  32  PC of the instruction.
REQ-012 inst_in_delay  out  1  instruction sits in a branch delay slot.
REQ-013 done_valid  in  1  core retired the presented instruction (1-cycle pulse).
REQ-014 done_branch  in  1  retired instruction was a taken branch/jump; qualifies done_valid.
REQ-015 done_target  in  32  branch target; qualifies done_branch.
REQ-016 flush_valid  in  1  redirect (exception/eret), highest priority.
REQ-017 flush_pc  in  32  redirect target.
REQ-018 fatal  out  1  sticky: branch retired inside a delay slot.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, HOLD.
REQ-020 IDLE -> REQ next cycle; REQ drives ireq_valid=1, ireq_addr=pc; REQ -> WAIT when ireq_ready.
REQ-021 WAIT: on iresp_valid capture data, -> HOLD; inst_valid=1 from the following cycle.
REQ-022 HOLD: inst/inst_pc/inst_in_delay stable until done_valid; done_valid outside HOLD SHALL be ignored.
REQ-023 On done_valid, no branch, delayed=0: pc <= pc+4, -> REQ.
REQ-024 On done_valid, done_branch, delayed=0: pc <= pc+4, delayed <= 1, delayed_pc <= done_target, -> REQ (delay slot fetched next, inst_in_delay=1).
REQ-025 On done_valid, delayed=1, no branch: pc <= delayed_pc, delayed <= 0, -> REQ.
REQ-026 On done_valid, delayed=1, done_branch: fatal <= 1 (sticky), behave as REQ-025.
REQ-027 flush_valid in any state: pc <= flush_pc, delayed <= 0, inst_valid <= 0, -> REQ; overrides simultaneous done_valid.
REQ-028 Flush during WAIT, or during REQ with ireq_ready=1 that cycle: one response SHALL be dropped (discard flag), next request not issued until that response arrives.
REQ-029 At most one outstanding request; ireq_addr stable while ireq_valid=1 and ireq_ready=0.
REQ-030 PC arithmetic modulo 2^32; pc+4 from 32'hfffffffc wraps to 0.
REQ-031 ireq_addr[1:0] nonzero SHALL still be issued unmodified; alignment checked by core.

Reset
REQ-032 resetn low: state=IDLE, pc=RESET_PC, delayed=0, delayed_pc=0, discard=0, fatal=0, ireq_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_in_delay=0.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; no discard carried over.

Structure
REQ-034 State enum fetch_state_t and RESET_PC default in shared package with refcpu defs.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Reset release, ireq_ready=1, response 1 cycle later -> ireq_addr=bfc00000, inst_valid 3 cycles after release.
REQ-037 Retire branch at bfc00000 target 80000000 -> next fetch bfc00004 inst_in_delay=1; retire it -> fetch 80000000, inst_in_delay=0.
REQ-038 Branch retired in delay slot -> fatal=1 held until reset, next fetch = original delayed_pc.
REQ-039 flush_valid in WAIT with flush_pc=bfc00380 -> stale response dropped, next ireq_addr=bfc00380, inst shows second response.
REQ-040 ireq_ready low 5 cycles -> ireq_valid/ireq_addr stable; flush and done_valid same cycle in HOLD -> flush target fetched, pc not incremented.
